word_stream_sequencer: RTL and testbench
========================================

# word_stream_sequencer

Sequencer placed upstream and downstream of the word selector in the RLS datapath. On `start` it latches a packed N-bit vector and drives that vector and a word index into the selector. It steps the index through every nBits-wide word, registers each selected word, and streams the words out with a valid/ready handshake. A last-word flag marks the final word, and a one-cycle `done` pulse reports completion.

## Interface
- `N`, 100, packed vector width in bits.
- `nBits`, 32, word width; NWORDS = N/nBits (integer division; trailing N mod nBits bits ignored); NWORDS ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a pass; sampled only in IDLE.
- `vec_in`  input  [0:N-1]  vector, latched on accepted `start`.
- `vec_sel`  output  [0:N-1]  latched vector, drives the selector's `in`.
- `seleccion`  output  [31:0]  word index, drives the selector's `seleccion`.
- `word_in`  input  [0:nBits-1]  selector output, combinational from `vec_sel`/`seleccion`.
- `out_word`  output  [0:nBits-1]  registered word.
- `out_valid`  output  1  `out_word` holds an unaccepted word.
- `out_ready`  input  1  consumer accepts when `out_valid` & `out_ready`.
- `out_last`  output  1  qualifies `out_word` as word NWORDS-1 of the pass (index 0 with the reverse macro).
- `busy`  output  1  high in states FILL and DRAIN.
- `done`  output  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, FILL, DRAIN.
- IDLE:
  - `start`=1: latch `vec_in` into `vec_sel`, set `seleccion` to the first index, go to FILL.
- FILL:
  - A load happens when `!out_valid || out_ready`.
  - On a load: `out_word`←`word_in`, `out_valid`←1, `out_last`←(`seleccion` == final index).
  - If the loaded index is not final, step `seleccion` (+1, or −1 in reverse).
  - If it is final, go to DRAIN.
- DRAIN:
  - On `out_valid` & `out_ready`: `out_valid`←0, `out_last`←0, pulse `done`, go to IDLE.
- Hold rule: while `out_valid` & !`out_ready`, `out_word`, `out_last` and `seleccion` hold.
- `vec_sel` changes only on an accepted `start`. Changes on `vec_in` mid-pass are ignored.
- `start` is ignored while `busy`. A `start` in the `done` cycle is not accepted; it is accepted from the following cycle (IDLE).
- `seleccion` always lies within [0, NWORDS-1]; zero-extended to 32 bits.

## Timing
- Reset values:
  - `vec_sel`=0, `seleccion`=0, `out_word`=0.
  - `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
  - State IDLE.
- `start` at cycle T → FILL at T+1 → first `out_valid` at T+2.
- With `out_ready` held high: one word per cycle at T+2 … T+NWORDS+1.
- `done` rises at T+NWORDS+2, the cycle after the last accepting edge.
- NWORDS=1: the single word carries `out_last`=1 and the FSM goes FILL→DRAIN immediately.
- Backpressure stalls do not change the order of words or the `done` behaviour.
- Reset asserted mid-pass aborts immediately to reset values; no `done` pulse.

## Configuration
- `WSEQ_REVERSE_EN` defined:
  - Pass starts at index NWORDS-1 and decrements.
  - `out_last` marks index 0.
- Undefined:
  - Pass starts at 0 and increments.
  - `out_last` marks NWORDS-1.
- All other timing is identical in both builds.

## Test plan
- Forward, N=100, nBits=32, `vec_in`={32'h11111111, 32'h22222222, 32'h33333333, 4'hF}, `out_ready`=1 → 32'h11111111, 22222222, 33333333 on three consecutive cycles.
  - `out_last` only on the third word.
  - `done` one cycle later; tail bits never appear.
- Backpressure: `out_ready` low 3 cycles on word 2 → word 2 held stable with `seleccion` frozen; no word lost or duplicated; `done` delayed by 3 cycles.
- `start` pulsed during FILL with a different `vec_in` → ignored; original words streamed, only one `done`.
- `rst_n` low after the first word → all outputs 0 asynchronously; a new `start` then streams a full pass from the first index.
- N=32, nBits=32 → single word with `out_last`=1, `done` at T+3.
- With `WSEQ_REVERSE_EN`, same vector as the first scenario → 33333333, 22222222, 11111111; `out_last` on 11111111.

Source files
------------

// File: rtl/word_stream_sequencer_if.sv
// Bus bundle between word_stream_sequencer, the word selector it drives and the word consumer.
// master = sequencer side, slave = selector/consumer side.
interface word_stream_sequencer_if #(
  parameter int N     = 100,
  parameter int nBits = 32
) ();
  logic             start;
  logic [0:N-1]     vec_in;
  logic [0:N-1]     vec_sel;
  logic [31:0]      seleccion;
  logic [0:nBits-1] word_in;
  logic [0:nBits-1] out_word;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    input  start, vec_in, word_in, out_ready,
    output vec_sel, seleccion, out_word, out_valid, out_last, busy, done
  );

  modport slave (
    output start, vec_in, word_in, out_ready,
    input  vec_sel, seleccion, out_word, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/word_stream_sequencer.sv
// Latches a packed vector, walks the word selector through its nBits-wide words and streams them
// out over valid/ready. Define WSEQ_REVERSE_EN to walk from the highest word index down to 0.
module word_stream_sequencer #(
  parameter int N     = 100,
  parameter int nBits = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  word_stream_sequencer_if.master   io_bus
);
  localparam int NWORDS = N / nBits;
  localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

`ifdef WSEQ_REVERSE_EN
  localparam logic [IW-1:0] FIRST_IDX = IW'(NWORDS - 1);
  localparam logic [IW-1:0] FINAL_IDX = '0;
`else
  localparam logic [IW-1:0] FIRST_IDX = '0;
  localparam logic [IW-1:0] FINAL_IDX = IW'(NWORDS - 1);
`endif

  // state | meaning
  // IDLE  | waiting for start (not accepted in the done cycle)
  // FILL  | loading selected words into the output register, stepping seleccion
  // DRAIN | final word loaded, waiting for it to be accepted
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [0:N-1]     r_vec, w_vec_nxt;
  logic [IW-1:0]    r_sel, w_sel_nxt;
  logic [0:nBits-1] r_word, w_word_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_last, w_last_nxt;
  logic             r_done, w_done_nxt;

  logic             w_load;
  logic             w_accept;
  logic             w_sel_final;
  logic [IW-1:0]    w_sel_step;

  assign w_accept    = r_valid && io_bus.out_ready;
  assign w_load      = (r_state == S_FILL) && (!r_valid || io_bus.out_ready);
  assign w_sel_final = (r_sel == FINAL_IDX);

`ifdef WSEQ_REVERSE_EN
  assign w_sel_step = r_sel - IW'(1);
`else
  assign w_sel_step = r_sel + IW'(1);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_sel_nxt   = r_sel;
    w_word_nxt  = r_word;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (io_bus.start && !r_done) begin
          w_vec_nxt   = io_bus.vec_in;
          w_sel_nxt   = FIRST_IDX;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        // a load also retires the word being accepted in the same cycle
        if (w_load) begin
          w_word_nxt  = io_bus.word_in;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_sel_final;
          if (w_sel_final) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_sel_nxt = w_sel_step;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_sel   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_sel   <= w_sel_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign io_bus.vec_sel   = r_vec;
  assign io_bus.seleccion = 32'(r_sel);
  assign io_bus.out_word  = r_word;
  assign io_bus.out_valid = r_valid;
  assign io_bus.out_last  = r_last;
  assign io_bus.busy      = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign io_bus.done      = r_done;
endmodule

// File: tb/tb_word_stream_sequencer.sv
// Bench for word_stream_sequencer: table-driven passes, hand-written corner sequences and
// randomized passes checked against a stream-level timing model of the word handshake.
`timescale 1ns/1ps
module tb_word_stream_sequencer;
  localparam int NA   = 100;
  localparam int NB   = 32;
  localparam int WB   = 32;
  localparam int NWA  = NA / WB;
  localparam int MAXJ = 48;
`ifdef WSEQ_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  word_stream_sequencer_if #(.N(NA), .nBits(WB)) bus_a ();
  word_stream_sequencer_if #(.N(NB), .nBits(WB)) bus_b ();

  word_stream_sequencer #(.N(NA), .nBits(WB)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
  word_stream_sequencer #(.N(NB), .nBits(WB)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));

  always #5 clk = ~clk;

  // word selector model: word k occupies bits [k*WB : k*WB+WB-1] of the vector
  logic [0:NA-1] w_sh_a;
  assign w_sh_a        = bus_a.vec_sel << (bus_a.seleccion * 32'(WB));
  assign bus_a.word_in = w_sh_a[0:WB-1];
  assign bus_b.word_in = bus_b.vec_sel << (bus_b.seleccion * 32'(WB));

  function automatic logic [31:0] word_of(logic [0:NA-1] v, int i);
    logic [0:NA-1] t;
    t = v << (i * WB);
    return t[0:WB-1];
  endfunction

  function automatic int idx_of(int k);
    return REV ? (NWA - 1 - k) : k;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  logic [31:0] got_w [3];
  int          got_n;
  int          got_done;

  // One pass on dut_a. Cycle j counts negedges after the edge that samples start.
  // Word k first shows at c[k] (2 for k=0, else the cycle after word k-1 is taken) and
  // is taken at a[k], the first cycle >= c[k] with ready high; done follows a[last].
  task automatic run_pass(input logic [0:NA-1] vec, input logic [MAXJ-1:0] rdy_low,
                          input bit noise, input bit done_start);
    bit rdy [MAXJ+2];
    int c [NWA];
    int a [NWA];
    int j, dj, pk, es;
    for (int i = 0; i < MAXJ + 2; i++) rdy[i] = (i < MAXJ) ? !rdy_low[i] : 1'b1;
    c[0] = 2;
    for (int k = 0; k < NWA; k++) begin
      j = c[k];
      while (!rdy[j] && j < MAXJ + 1) j++;
      a[k] = j;
      if (k < NWA - 1) c[k+1] = j + 1;
    end
    dj       = a[NWA-1] + 1;
    got_n    = 0;
    got_done = -1;
    bus_a.start  = 1'b1;
    bus_a.vec_in = vec;
    for (j = 1; j <= dj + 1; j++) begin
      @(negedge clk);
      pk = -1;
      for (int k = 0; k < NWA; k++) if (c[k] <= j && j <= a[k]) pk = k;
      es = (j == 1) ? idx_of(0) : (pk >= 0 && pk < NWA - 1) ? idx_of(pk + 1) : idx_of(NWA - 1);
      chk($sformatf("busy_j%0d", j),  bus_a.busy,      (j <= a[NWA-1]));
      chk($sformatf("done_j%0d", j),  bus_a.done,      (j == dj));
      chk($sformatf("valid_j%0d", j), bus_a.out_valid, (pk >= 0));
      chk($sformatf("last_j%0d", j),  bus_a.out_last,  (pk == NWA - 1));
      chk($sformatf("vsel_j%0d", j),  bus_a.vec_sel,   vec);
      chk($sformatf("sel_j%0d", j),   bus_a.seleccion, es);
      if (pk >= 0) chk($sformatf("word_j%0d", j), bus_a.out_word, word_of(vec, idx_of(pk)));
      if (bus_a.out_valid && rdy[j] && got_n < 3) begin
        got_w[got_n] = bus_a.out_word;
        got_n++;
      end
      if (bus_a.done) got_done = j;
      bus_a.out_ready = rdy[j];
      bus_a.vec_in    = {$urandom, $urandom, $urandom, 4'($urandom)};
      if (j == dj)     bus_a.start = done_start;
      else if (j < dj) bus_a.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      else             bus_a.start = 1'b0;
    end
  endtask

  typedef struct {
    logic [0:NA-1]   vec;
    logic [MAXJ-1:0] rdy_low;
    bit              noise;
    bit              done_start;
    logic [31:0]     w0, w1, w2;
    int              done_j;
  } vec_t;

  localparam logic [0:NA-1] V1 = {32'h11111111, 32'h22222222, 32'h33333333, 4'hF};
  localparam logic [0:NA-1] V2 = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'hDEADBEEF, 4'h3};

  vec_t tbl [4];

  initial begin
    tbl[0] = '{V1, 48'h0,  1'b0, 1'b0, REV ? 32'h33333333 : 32'h11111111, 32'h22222222,
               REV ? 32'h11111111 : 32'h33333333, 5};
    tbl[1] = '{V1, 48'h38, 1'b0, 1'b0, REV ? 32'h33333333 : 32'h11111111, 32'h22222222,
               REV ? 32'h11111111 : 32'h33333333, 8};
    tbl[2] = '{V1, 48'h0,  1'b1, 1'b1, REV ? 32'h33333333 : 32'h11111111, 32'h22222222,
               REV ? 32'h11111111 : 32'h33333333, 5};
    tbl[3] = '{V2, 48'h4,  1'b0, 1'b0, REV ? 32'hDEADBEEF : 32'hA5A5A5A5, 32'h0F0F0F0F,
               REV ? 32'hA5A5A5A5 : 32'hDEADBEEF, 6};

    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.vec_in = '0; bus_a.out_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.vec_in = '0; bus_b.out_ready = 1'b0;
    #12;
    chk("rst_vsel",  bus_a.vec_sel,   0);
    chk("rst_sel",   bus_a.seleccion, 0);
    chk("rst_word",  bus_a.out_word,  0);
    chk("rst_valid", bus_a.out_valid, 0);
    chk("rst_last",  bus_a.out_last,  0);
    chk("rst_busy",  bus_a.busy,      0);
    chk("rst_done",  bus_a.done,      0);
    chk("rst_b_valid", bus_b.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      run_pass(tbl[t].vec, tbl[t].rdy_low, tbl[t].noise, tbl[t].done_start);
      chk($sformatf("tbl%0d_count", t), got_n, 3);
      chk($sformatf("tbl%0d_w0", t), got_w[0], tbl[t].w0);
      chk($sformatf("tbl%0d_w1", t), got_w[1], tbl[t].w1);
      chk($sformatf("tbl%0d_w2", t), got_w[2], tbl[t].w2);
      chk($sformatf("tbl%0d_done", t), got_done, tbl[t].done_j);
    end

    // reset in the middle of a pass, after the first word has been taken
    bus_a.out_ready = 1'b1; bus_a.vec_in = V2; bus_a.start = 1'b1;
    @(negedge clk); bus_a.start = 1'b0;
    @(negedge clk); chk("ab_w0", bus_a.out_word, word_of(V2, idx_of(0)));
    @(negedge clk); chk("ab_w1", bus_a.out_word, word_of(V2, idx_of(1)));
    #1 rst_n = 1'b0;
    #1;
    chk("ab_vsel",  bus_a.vec_sel,   0);
    chk("ab_sel",   bus_a.seleccion, 0);
    chk("ab_word",  bus_a.out_word,  0);
    chk("ab_valid", bus_a.out_valid, 0);
    chk("ab_last",  bus_a.out_last,  0);
    chk("ab_busy",  bus_a.busy,      0);
    @(negedge clk); chk("ab_done_rst", bus_a.done, 0);
    rst_n = 1'b1;
    @(negedge clk); chk("ab_done_after", bus_a.done, 0);
    chk("ab_busy_after", bus_a.busy, 0);
    run_pass(V1, 48'h0, 1'b0, 1'b0);
    chk("ab_restart_w0", got_w[0], REV ? 32'h33333333 : 32'h11111111);

    // single-word build: N == nBits
    bus_b.out_ready = 1'b1; bus_b.vec_in = 32'hCAFEF00D; bus_b.start = 1'b1;
    @(negedge clk); bus_b.start = 1'b0;
    chk("b1_busy", bus_b.busy, 1); chk("b1_valid", bus_b.out_valid, 0);
    @(negedge clk);
    chk("b2_valid", bus_b.out_valid, 1); chk("b2_word", bus_b.out_word, 32'hCAFEF00D);
    chk("b2_last", bus_b.out_last, 1);   chk("b2_sel", bus_b.seleccion, 0);
    chk("b2_done", bus_b.done, 0);
    @(negedge clk);
    chk("b3_done", bus_b.done, 1); chk("b3_valid", bus_b.out_valid, 0);
    chk("b3_busy", bus_b.busy, 0); chk("b3_last", bus_b.out_last, 0);
    @(negedge clk);
    chk("b4_done", bus_b.done, 0);

    for (int r = 0; r < 25; r++) begin
      run_pass({$urandom, $urandom, $urandom, 4'($urandom)},
               {16'h0, $urandom & $urandom}, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      chk($sformatf("rnd%0d_count", r), got_n, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
